jtopl_reg_up: RTL

JTOPL_REG_UP -- requirements
Module: jtopl_reg_up

---
 rtl/jtopl_pkg.sv | 36 +++
 rtl/jtopl_slot_dec.sv | 19 +
 rtl/jtopl_reg_up.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants for the operator register update path: slot count,
// register group bases, FSM encoding and the group-to-strobe decode.
package jtopl_pkg;

    localparam int NUM_SLOTS = 18;
    localparam logic [4:0] ROW_SLOTS = 5'd6;

    localparam logic [7:0] GRP_MULT   = 8'h20;
    localparam logic [7:0] GRP_KSL_TL = 8'h40;
    localparam logic [7:0] GRP_AR_DR  = 8'h60;
    localparam logic [7:0] GRP_SL_RR  = 8'h80;
    localparam logic [7:0] GRP_WAV    = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // One-hot field-group select: bit0 mult .. bit4 wav; zero when the
    // upper address bits name no operator group.
    function automatic logic [4:0] grp_sel(input logic [7:0] a);
        logic [4:0] s;
        s = '0;
        case (a[7:5])
            GRP_MULT[7:5]:   s[0] = 1'b1;
            GRP_KSL_TL[7:5]: s[1] = 1'b1;
            GRP_AR_DR[7:5]:  s[2] = 1'b1;
            GRP_SL_RR[7:5]:  s[3] = 1'b1;
            GRP_WAV[7:5]:    s[4] = 1'b1;
            default:         s    = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/jtopl_slot_dec.sv
// Maps the 5-bit register offset onto an operator slot: three rows of six
// operators, offsets 6/7 of each row and row 3 are holes.
module jtopl_slot_dec
    import jtopl_pkg::*;
(
    input  logic [4:0] i_offset,
    output logic [4:0] o_slot,
    output logic       o_valid
);

    logic [4:0] w_base;

    always_comb begin
        w_base  = 5'(i_offset[4:3]) * ROW_SLOTS;
        o_slot  = w_base + {2'b00, i_offset[2:0]};
        o_valid = (i_offset[4:3] != 2'd3) && (i_offset[2:0] <= 3'd5);
    end

endmodule

// File: rtl/jtopl_reg_up.sv
// Operator register write scheduler: latches a bus write and releases it to
// the circular operator register stage when the target slot comes around.
//
//   state | meaning
//   IDLE  | no write pending, accepts a new data write
//   WAIT  | write captured, waiting for slot == target
//   HOLD  | slot reached, counting cen to emit update_op_II / update_op_IV
module jtopl_reg_up
    import jtopl_pkg::*;
#(
    parameter int SLOTS = NUM_SLOTS
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       update_op_I,
    output logic       update_op_II,
    output logic       update_op_IV,
    output logic       busy,
    output logic [4:0] slot
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

    state_e     r_state;
    state_e     w_next;
    logic [4:0] r_slot;
    logic [7:0] r_addr;
    logic [7:0] r_dout;
    logic [4:0] r_up;
    logic [4:0] r_target;
    logic [1:0] r_cnt;

    logic       w_wr_addr;
    logic       w_wr_data;
    logic [4:0] w_tgt;
    logic       w_tgt_ok;
    logic [4:0] w_grp;
    logic       w_start;
    logic       w_match;

    jtopl_slot_dec u_slot_dec (
        .i_offset (r_addr[4:0]),
        .o_slot   (w_tgt),
        .o_valid  (w_tgt_ok)
    );

    assign w_wr_addr = ~wr_n & ~addr;
    assign w_wr_data = ~wr_n &  addr;
    assign w_grp     = grp_sel(r_addr);
    // Data writes while busy fall through here and are simply dropped.
    assign w_start   = (r_state == ST_IDLE) && w_wr_data && w_tgt_ok && (|w_grp);
    assign w_match   = (r_slot == r_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)              w_next = ST_WAIT;
            ST_WAIT: if (cen && w_match)       w_next = ST_HOLD;
            ST_HOLD: if (cen && r_cnt == 2'd3) w_next = ST_IDLE;
            default:                           w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot   <= '0;
            r_addr   <= '0;
            r_dout   <= '0;
            r_up     <= '0;
            r_target <= '0;
            r_cnt    <= '0;
        end else begin
            if (cen) begin
                r_slot <= (r_slot == SLOT_LAST) ? 5'd0 : r_slot + 5'd1;
            end
            if (w_wr_addr) begin
                r_addr <= din;
            end
            if (w_start) begin
                r_dout   <= din;
                r_target <= w_tgt;
                r_up     <= w_grp;
            end
            if (r_state == ST_WAIT && cen && w_match) begin
                r_cnt <= 2'd1;
            end else if (r_state == ST_HOLD && cen) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_up <= '0;
                end
            end
        end
    end

    always_comb begin
        busy         = (r_state != ST_IDLE);
        update_op_I  = (r_state == ST_WAIT) && w_match;
        update_op_II = (r_state == ST_HOLD) && (r_cnt == 2'd1);
        update_op_IV = (r_state == ST_HOLD) && (r_cnt == 2'd3);
        dout         = r_dout;
        slot         = r_slot;
        up_mult      = r_up[0];
        up_ksl_tl    = r_up[1];
        up_ar_dr     = r_up[2];
        up_sl_rr     = r_up[3];
        up_wav       = r_up[4];
    end

endmodule
